mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS main controller. It drives the ALU's 3-bit aluop select and consumes the ALU's zero and oflow status flags.
- It sequences fetch/decode/execute/memory/writeback for the supported instruction subset and emits datapath enables and mux selects each cycle.
- Sits between the instruction register and the datapath (PC, register file, memory, ALU).

---
 rtl/mips_ctrl_pkg.sv | 58 +++++
 rtl/mips_multicycle_ctrl_aluop_decode.sv | 27 ++
 rtl/mips_multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALU operation select
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_SLT = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b011;
    localparam logic [2:0] ALUOP_LUI = 3'b100;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU  = 2'd0;
    localparam logic [1:0] PCSRC_BRT  = 2'd1;
    localparam logic [1:0] PCSRC_JUMP = 2'd2;

    // Controller states; encodings 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // True for the R-type function codes the controller executes
    function automatic logic is_legal_funct(input logic [5:0] fn);
        return (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_aluop_decode.sv
// rtl/mips_multicycle_ctrl_aluop_decode.sv - opcode/funct to ALU operation select
module aluop_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_aluop
);

    // Anything not recognised maps to add so the ALU never sees 101-111
    always_comb begin
        o_aluop = ALUOP_ADD;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_SUBU: o_aluop = ALUOP_SUB;
                    FN_SLT:  o_aluop = ALUOP_SLT;
                    default: o_aluop = ALUOP_ADD;
                endcase
            end
            OP_ORI:  o_aluop = ALUOP_OR;
            OP_LUI:  o_aluop = ALUOP_LUI;
            default: o_aluop = ALUOP_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main controller (option: ADDI_OFLOW_TRAP_EN)
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       oflow,
    output logic [2:0] aluop,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       ir_we,
    output logic       mem_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
`ifdef ADDI_OFLOW_TRAP_EN
    ,
    output logic       ovf_trap
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_dec_aluop;

    aluop_decode u_aluop_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_aluop  (w_dec_aluop)
    );

    assign state = r_state;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

`ifdef ADDI_OFLOW_TRAP_EN
    logic r_ovf;

    // Capture addi overflow while the add is on the ALU, consumed in WB_I
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_EXEC_I) begin
            r_ovf <= (opcode == OP_ADDI) && oflow;
        end
    end

    assign ovf_trap = !rst && (r_state == S_WB_I) && r_ovf;
`else
    logic w_unused_oflow;
    assign w_unused_oflow = oflow;
`endif

    // Next-state and Moore outputs; reset overrides enables last
    always_comb begin
        w_next     = S_FETCH;
        aluop      = ALUOP_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ext_op     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        i_or_d     = 1'b0;
        ir_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_we     = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_we     = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while dispatching
                alu_src_b = SRCB_IMM_SH;
                ext_op    = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (is_legal_funct(funct)) w_next = S_EXEC_R;
                        else                       illegal = 1'b1;
                    end
                    OP_ORI, OP_LUI, OP_ADDI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:            w_next = S_MEM_ADDR;
                    OP_BEQ:                  w_next = S_BRANCH;
                    OP_J:                    w_next = S_JUMP;
                    default:                 illegal = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                aluop     = w_dec_aluop;
                w_next    = S_WB_R;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = w_dec_aluop;
                ext_op    = (opcode != OP_ORI);
                w_next    = S_WB_I;
            end
            S_WB_I: begin
`ifdef ADDI_OFLOW_TRAP_EN
                reg_we = !r_ovf;
`else
                reg_we = 1'b1;
`endif
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
                w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                i_or_d = 1'b1;
                w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                i_or_d = 1'b1;
                mem_we = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                pc_src    = PCSRC_BRT;
                pc_we     = zero;
            end
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_we  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (rst) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            mem_we  = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
            aluop   = ALUOP_ADD;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, oflow;
    logic [2:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op, pc_we;
    logic [1:0] pc_src;
    logic       i_or_d, ir_we, mem_we, reg_we, reg_dst, mem_to_reg, illegal;
    logic [3:0] state;
`ifdef ADDI_OFLOW_TRAP_EN
    logic       ovf_trap;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .oflow      (oflow),
        .aluop      (aluop),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .i_or_d     (i_or_d),
        .ir_we      (ir_we),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state)
`ifdef ADDI_OFLOW_TRAP_EN
        ,
        .ovf_trap   (ovf_trap)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH to its last cycle, checking each cycle
    // against the instruction-level rules (which cycle writes what).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int omode);
        int         kind, lat;
        logic       z, o, last, ovf_seen;
        logic [4:0] exp_we, obs_we;
        logic [2:0] exp_alu;
        case (op)
            6'b000000: kind = (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b101010) ? K_R : K_ILL;
            6'b001101, 6'b001111, 6'b001000: kind = K_I;
            6'b100011: kind = K_LW;
            6'b101011: kind = K_SW;
            6'b000100: kind = K_BEQ;
            6'b000010: kind = K_J;
            default:   kind = K_ILL;
        endcase
        case (kind)
            K_LW:         lat = 5;
            K_BEQ, K_J:   lat = 3;
            K_ILL:        lat = 2;
            default:      lat = 4;
        endcase
        ovf_seen = 1'b0;
        for (int c = 0; c < lat; c++) begin
            opcode = (c == 0) ? 6'($urandom) : op;
            funct  = (c == 0) ? 6'($urandom) : fn;
            z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            o = (omode < 0) ? 1'($urandom) : 1'(omode);
            zero  = z;
            oflow = o;
            @(negedge clk);
            last = (c == lat - 1);

            exp_we[4] = (c == 1) && (kind == K_ILL);
            exp_we[3] = (c == 0);
            exp_we[2] = (c == 0) || (kind == K_J && last) || (kind == K_BEQ && c == 2 && z);
            exp_we[1] = (kind == K_SW) && last;
            exp_we[0] = last && (kind == K_R || kind == K_I || kind == K_LW);
`ifdef ADDI_OFLOW_TRAP_EN
            if (kind == K_I && op == 6'b001000 && ovf_seen) exp_we[0] = 1'b0;
`endif
            obs_we = {illegal, ir_we, pc_we, mem_we, reg_we};
            n_checks++;
            if (obs_we !== exp_we) begin
                n_errors++;
                $display("FAIL enables op=%b fn=%b cyc=%0d ill/ir/pc/mem/reg got %b want %b", op, fn, c, obs_we, exp_we);
            end

            n_checks++;
            if (aluop > 3'd4) begin
                n_errors++;
                $display("FAIL aluop_range cyc=%0d got %b want <=100", c, aluop);
            end

`ifdef ADDI_OFLOW_TRAP_EN
            n_checks++;
            if (ovf_trap !== (kind == K_I && op == 6'b001000 && c == 3 && ovf_seen)) begin
                n_errors++;
                $display("FAIL ovf_trap op=%b cyc=%0d got %b want %b", op, c, ovf_trap,
                         (kind == K_I && op == 6'b001000 && c == 3 && ovf_seen));
            end
`endif

            if (c == 0) begin
                n_checks++;
                if ({state, alu_src_a, alu_src_b, pc_src, i_or_d, aluop} !== {4'd0, 1'b0, 2'd1, 2'd0, 1'b0, 3'd0}) begin
                    n_errors++;
                    $display("FAIL fetch state/srca/srcb/pcsrc/iord/aluop got %0d %b %0d %0d %b %b want 0 0 1 0 0 000",
                             state, alu_src_a, alu_src_b, pc_src, i_or_d, aluop);
                end
            end else if (c == 1) begin
                n_checks++;
                if ({alu_src_a, alu_src_b, ext_op, aluop} !== {1'b0, 2'd3, 1'b1, 3'd0}) begin
                    n_errors++;
                    $display("FAIL decode srca/srcb/ext/aluop got %b %0d %b %b want 0 3 1 000",
                             alu_src_a, alu_src_b, ext_op, aluop);
                end
            end else if (c == 2 && kind != K_J) begin
                exp_alu = 3'b000;
                if (kind == K_R)   exp_alu = (fn == 6'b100011) ? 3'b011 : (fn == 6'b101010) ? 3'b010 : 3'b000;
                if (kind == K_I)   exp_alu = (op == 6'b001101) ? 3'b001 : (op == 6'b001111) ? 3'b100 : 3'b000;
                if (kind == K_BEQ) exp_alu = 3'b011;
                n_checks++;
                if ({aluop, alu_src_a, alu_src_b} !== {exp_alu, 1'b1, (kind == K_R || kind == K_BEQ) ? 2'd0 : 2'd2}) begin
                    n_errors++;
                    $display("FAIL exec op=%b fn=%b aluop/srca/srcb got %b %b %0d want %b 1 %0d", op, fn,
                             aluop, alu_src_a, alu_src_b, exp_alu, (kind == K_R || kind == K_BEQ) ? 0 : 2);
                end
                if (kind == K_LW || kind == K_SW || (kind == K_I && op != 6'b001111)) begin
                    n_checks++;
                    if (ext_op !== (op != 6'b001101)) begin
                        n_errors++;
                        $display("FAIL ext_op op=%b got %b want %b", op, ext_op, (op != 6'b001101));
                    end
                end
                if (kind == K_BEQ) begin
                    n_checks++;
                    if (pc_src !== 2'd1) begin
                        n_errors++;
                        $display("FAIL beq_pc_src got %0d want 1", pc_src);
                    end
                end
            end
            if (c >= 2 && last && kind != K_BEQ) begin
                n_checks++;
                case (kind)
                    K_R: if ({reg_dst, mem_to_reg} !== 2'b10) begin
                        n_errors++; $display("FAIL wb_r dst/m2r got %b%b want 10", reg_dst, mem_to_reg);
                    end
                    K_I: if ({reg_dst, mem_to_reg} !== 2'b00) begin
                        n_errors++; $display("FAIL wb_i dst/m2r got %b%b want 00", reg_dst, mem_to_reg);
                    end
                    K_LW: if ({reg_dst, mem_to_reg} !== 2'b01) begin
                        n_errors++; $display("FAIL mem_wb dst/m2r got %b%b want 01", reg_dst, mem_to_reg);
                    end
                    K_SW: if (i_or_d !== 1'b1) begin
                        n_errors++; $display("FAIL mem_wr i_or_d got %b want 1", i_or_d);
                    end
                    default: if (pc_src !== 2'd2) begin
                        n_errors++; $display("FAIL jump pc_src got %0d want 2", pc_src);
                    end
                endcase
            end
            if (kind == K_LW && c == 3) begin
                n_checks++;
                if (i_or_d !== 1'b1) begin
                    n_errors++;
                    $display("FAIL mem_rd i_or_d got %b want 1", i_or_d);
                end
            end
            if (c == 2 && kind == K_I && op == 6'b001000) ovf_seen = o;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; oflow = 1'b0;
        tick(); tick();
        rst = 1'b0;
        // Walk a lw into its MEM_RD cycle, then abort it
        opcode = 6'b100011;
        tick(); tick(); tick();
        @(negedge clk);
        n_checks++;
        if (i_or_d !== 1'b1) begin
            n_errors++; $display("FAIL reset_setup i_or_d got %b want 1", i_or_d);
        end
        #2;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({reg_we, mem_we, pc_we, ir_we, illegal, aluop} !== 8'b0) begin
                n_errors++;
                $display("FAIL reset_hold cyc=%0d we/ill/aluop got %b want 00000000", k,
                         {reg_we, mem_we, pc_we, ir_we, illegal, aluop});
            end
            tick();
        end
        n_checks++;
        if (state !== 4'd0) begin
            n_errors++; $display("FAIL reset_state got %0d want 0", state);
        end
        rst = 1'b0;
        opcode = 6'b111111;
        @(negedge clk);
        n_checks++;
        if ({state, ir_we, pc_we, reg_we, mem_we} !== {4'd0, 4'b1100}) begin
            n_errors++;
            $display("FAIL post_reset state/ir/pc/reg/mem got %0d %b want 0 1100", state, {ir_we, pc_we, reg_we, mem_we});
        end
        tick(); tick();
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b100011, -1, -1);
        run_instr(6'b000000, 6'b100001, -1, -1);
        run_instr(6'b000000, 6'b101010, -1, -1);
    endtask

    task automatic test_mem();
        run_instr(6'b100011, 6'($urandom), -1, -1);
        run_instr(6'b101011, 6'($urandom), -1, -1);
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'($urandom), 1, -1);
        run_instr(6'b000100, 6'($urandom), 0, -1);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'($urandom), -1, -1);
        run_instr(6'b000000, 6'b000000, -1, -1);
        run_instr(6'b000010, 6'($urandom), -1, -1);
    endtask

    task automatic test_addi();
        run_instr(6'b001000, 6'($urandom), -1, 1);
        run_instr(6'b001000, 6'($urandom), -1, 0);
        run_instr(6'b001101, 6'($urandom), -1, 1);
        run_instr(6'b001111, 6'($urandom), -1, 1);
    endtask

    task automatic test_random();
        logic [5:0] ops [10];
        logic [5:0] fns [4];
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b001000,
                6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000000};
        fns = '{6'b100001, 6'b100011, 6'b101010, 6'b000000};
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            fn = fns[$urandom_range(0, 3)];
            if (fn == 6'b000000) fn = 6'($urandom);
            run_instr(op, fn, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_beq();
        test_illegal();
        test_addi();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
